// File: rtl/pppc_pkg.sv
// rtl/pppc_pkg.sv - shared constants for the ping-pong counter 7-segment display
package pppc_pkg;

  localparam int CNT_W = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_UP    = 7'h5C;
  localparam logic [6:0] SEG_DOWN  = 7'h63;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Active-low {g,f,e,d,c,b,a} patterns for decimal digits 0..9
  localparam logic [6:0] SEG_DIGITS [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

endpackage

// File: rtl/pppc_seg7_display_if.sv
// rtl/pppc_seg7_display_if.sv - counter-to-display bundle: count/direction in, digit/segment drive out
interface pppc_seg7_display_if;
  import pppc_pkg::*;

  logic [CNT_W-1:0] cnt_in;
  logic             dir_in;
  logic [3:0]       an;
  logic [6:0]       seg;

  modport master (output cnt_in, output dir_in, input an, input seg);
  modport slave  (input cnt_in, input dir_in, output an, output seg);

endinterface

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - combinational 4-bit code to active-low 7-segment pattern, blank above 9
module seg7_decoder
  import pppc_pkg::*;
(
  input  logic [CNT_W-1:0] code,
  output logic [6:0]       seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (code < CNT_W'(10)) seg = SEG_DIGITS[code];
  end

endmodule

// File: rtl/pppc_seg7_display.sv
// rtl/pppc_seg7_display.sv - 4-digit multiplexed display of count (tens/ones) and direction glyph; PPPC_LEADING_ZERO_BLANK_EN darkens a zero tens digit
module pppc_seg7_display
  import pppc_pkg::*;
#(
  parameter int DIV_WIDTH = 17
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pppc_seg7_display_if.slave   bus
);

  logic [DIV_WIDTH-1:0] scan;
  logic [1:0]           sel;
  logic [CNT_W-1:0]     snap_val;
  logic                 snap_dir;
  logic                 tens;
  logic [CNT_W-1:0]     ones;
  logic [CNT_W-1:0]     dec_code;
  logic [6:0]           dec_seg;
  logic [6:0]           glyph;
  logic                 blank_tens;
  logic [3:0]           an_nxt;
  logic [6:0]           seg_nxt;
  logic [3:0]           an_q;
  logic [6:0]           seg_q;

  assign sel = scan[DIV_WIDTH-1 -: 2];

  // Inputs are only taken on the last cycle of a frame so a frame never mixes two values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan     <= '0;
      snap_val <= '0;
      snap_dir <= 1'b1;
      an_q     <= AN_OFF;
      seg_q    <= SEG_BLANK;
    end else begin
      scan  <= scan + 1'b1;
      an_q  <= an_nxt;
      seg_q <= seg_nxt;
      if (scan == '1) begin
        snap_val <= bus.cnt_in;
        snap_dir <= bus.dir_in;
      end
    end
  end

  assign tens     = (snap_val >= CNT_W'(10));
  assign ones     = snap_val - (tens ? CNT_W'(10) : CNT_W'(0));
  assign dec_code = (sel == 2'd3) ? {{(CNT_W-1){1'b0}}, tens} : ones;
  assign glyph    = snap_dir ? SEG_UP : SEG_DOWN;

`ifdef PPPC_LEADING_ZERO_BLANK_EN
  assign blank_tens = !tens;
`else
  assign blank_tens = 1'b0;
`endif

  seg7_decoder u_dec (
    .code (dec_code),
    .seg  (dec_seg)
  );

  always_comb begin
    an_nxt  = AN_OFF;
    seg_nxt = SEG_BLANK;
    case (sel)
      2'd0: begin an_nxt = 4'b1110; seg_nxt = glyph;   end
      2'd1: begin an_nxt = 4'b1101; seg_nxt = glyph;   end
      2'd2: begin an_nxt = 4'b1011; seg_nxt = dec_seg; end
      default: begin
        if (!blank_tens) begin
          an_nxt  = 4'b0111;
          seg_nxt = dec_seg;
        end
      end
    endcase
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;

endmodule

// File: tb/tb_pppc_seg7_display.sv
// tb/tb_pppc_seg7_display.sv - self-checking bench for pppc_seg7_display with DIV_WIDTH=4
module tb_pppc_seg7_display;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pppc_seg7_display_if bus();

  pppc_seg7_display #(.DIV_WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  localparam logic [6:0] DIG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                      7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
`ifdef PPPC_LEADING_ZERO_BLANK_EN
  localparam logic [3:0] T0_AN  = 4'b1111;
  localparam logic [6:0] T0_SEG = 7'h7F;
`else
  localparam logic [3:0] T0_AN  = 4'b0111;
  localparam logic [6:0] T0_SEG = 7'h40;
`endif

  // Model: cycle position within a 16-cycle frame picks the slot; a frame shows the inputs seen on the previous frame's last cycle
  int         k     = 0;
  int         m_val = 0;
  logic       m_dir = 1'b1;
  logic [3:0] e_an  = 4'b1111;
  logic [6:0] e_seg = 7'h7F;
  bit         seen7 = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k = 0; m_val = 0; m_dir = 1'b1; e_an = 4'b1111; e_seg = 7'h7F;
    end else begin
      int pos, slot;
      pos  = k % 16;
      slot = pos / 4;
      case (slot)
        0: begin e_an = 4'b1110; e_seg = m_dir ? 7'h5C : 7'h63; end
        1: begin e_an = 4'b1101; e_seg = m_dir ? 7'h5C : 7'h63; end
        2: begin e_an = 4'b1011; e_seg = DIG[m_val % 10]; end
        default: begin
`ifdef PPPC_LEADING_ZERO_BLANK_EN
          if (m_val / 10 == 0) begin e_an = 4'b1111; e_seg = 7'h7F; end
          else begin e_an = 4'b0111; e_seg = DIG[m_val / 10]; end
`else
          e_an = 4'b0111; e_seg = DIG[m_val / 10];
`endif
        end
      endcase
      if (pos == 15) begin
        m_val = int'(bus.cnt_in);
        m_dir = bus.dir_in;
      end
      k++;
    end
  end

  always @(negedge clk) begin
    check("model_an", bus.an, e_an);
    check("model_seg", bus.seg, e_seg);
    if (bus.seg == 7'h78) seen7 = 1'b1;
  end

  task automatic slot(input string nm, input logic [3:0] a, input logic [6:0] s);
    repeat (4) begin
      @(negedge clk);
      check({nm, "_an"}, bus.an, a);
      check({nm, "_seg"}, bus.seg, s);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cnt_in = 4'd0;
    bus.dir_in = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_an", bus.an, 4'b1111);
    check("reset_seg", bus.seg, 7'h7F);
    rst_n = 1'b1;

    // first frame: reset snapshot "00", up glyph; 13/down applied mid-frame
    slot("f0_s0", 4'b1110, 7'h5C);
    bus.cnt_in = 4'd13; bus.dir_in = 1'b0;
    slot("f0_s1", 4'b1101, 7'h5C);
    slot("f0_s2", 4'b1011, 7'h40);
    slot("f0_s3", T0_AN, T0_SEG);

    slot("f1_s0", 4'b1110, 7'h63);
    bus.cnt_in = 4'd9; bus.dir_in = 1'b1;
    slot("f1_s1", 4'b1101, 7'h63);
    slot("f1_s2", 4'b1011, 7'h30);
    slot("f1_s3", 4'b0111, 7'h79);

    slot("f2_s0", 4'b1110, 7'h5C);
    bus.cnt_in = 4'd10;
    slot("f2_s1", 4'b1101, 7'h5C);
    slot("f2_s2", 4'b1011, 7'h10);
    slot("f2_s3", T0_AN, T0_SEG);

    slot("f3_s0", 4'b1110, 7'h5C);
    bus.cnt_in = 4'd15; bus.dir_in = 1'b0;
    slot("f3_s1", 4'b1101, 7'h5C);
    slot("f3_s2", 4'b1011, 7'h40);
    slot("f3_s3", 4'b0111, 7'h79);

    // glitch 3 -> 7 -> 3 inside one frame
    seen7 = 1'b0;
    slot("f4_s0", 4'b1110, 7'h63);
    bus.cnt_in = 4'd3; bus.dir_in = 1'b1;
    slot("f4_s1", 4'b1101, 7'h63);
    bus.cnt_in = 4'd7;
    slot("f4_s2", 4'b1011, 7'h12);
    bus.cnt_in = 4'd3;
    slot("f4_s3", 4'b0111, 7'h79);

    slot("f5_s0", 4'b1110, 7'h5C);
    slot("f5_s1", 4'b1101, 7'h5C);
    slot("f5_s2", 4'b1011, 7'h30);
    slot("f5_s3", T0_AN, T0_SEG);
    check("glitch_never_7", 32'(seen7), 32'd0);

    // asynchronous reset with the scan counter at 6
    slot("f6_s0", 4'b1110, 7'h5C);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_an", bus.an, 4'b1111);
    check("async_rst_seg", bus.seg, 7'h7F);
    repeat (2) @(negedge clk);
    check("async_hold_an", bus.an, 4'b1111);
    rst_n = 1'b1;

    slot("f7_s0", 4'b1110, 7'h5C);
    bus.cnt_in = 4'd12;
    slot("f7_s1", 4'b1101, 7'h5C);
    slot("f7_s2", 4'b1011, 7'h40);
    slot("f7_s3", T0_AN, T0_SEG);

    slot("f8_s0", 4'b1110, 7'h5C);
    slot("f8_s1", 4'b1101, 7'h5C);
    slot("f8_s2", 4'b1011, 7'h24);
    slot("f8_s3", 4'b0111, 7'h79);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
